benes_unpermute_6: RTL and testbench

//  Inverse of the 6-bit Benes permutation used by the L1 Random Modulo index mapping.

---
 rtl/benes_unpermute_6_if.sv | 24 ++
 rtl/benes_unpermute_6.sv | 103 ++++++++++
 tb/tb_benes_unpermute_6.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/benes_unpermute_6_if.sv
// Handshake bundle for the 6-bit inverse Benes unit: data in, data out, key load and idle status.
// The slave modport is the unpermuter and the master modport is whoever feeds and drains it.
interface benes_unpermute_6_if;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_word;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_word;
    logic        key_valid;
    logic        key_ready;
    logic [11:0] key_i;
    logic        idle;

    modport slave (
        input  in_valid, in_word, out_ready, key_valid, key_i,
        output in_ready, out_valid, out_word, key_ready, idle
    );

    modport master (
        output in_valid, in_word, out_ready, key_valid, key_i,
        input  in_ready, out_valid, out_word, key_ready, idle
    );
endinterface

// File: rtl/benes_unpermute_6.sv
// Three-stage inverse of the 6-bit Benes permutation used for random-modulo set indexing.
// Words stay lane-interleaved throughout: subnet-high lane j is bit 2j+1 and subnet-low lane j is bit 2j.
module benes_unpermute_6 (
    input  logic clk,
    input  logic reset,
    benes_unpermute_6_if.slave bus
);
    logic [11:0] key_q, key_d;
    logic        v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [5:0]  w1_q, w1_d, w2_q, w2_d, w3_q, w3_d;
    logic        en1, en2, en3;
    logic        inReady, keyReady, isIdle, inFire, keyFire;

    function automatic logic [5:0] pairSwap(input logic [5:0] w, input logic [2:0] sel);
        logic [5:0] r;
        r = w;
        if (sel[0]) {r[1], r[0]} = {w[0], w[1]};
        if (sel[1]) {r[3], r[2]} = {w[2], w[3]};
        if (sel[2]) {r[5], r[4]} = {w[4], w[5]};
        return r;
    endfunction

    function automatic logic [5:0] swap01(input logic [5:0] w, input logic hiEn, input logic loEn);
        logic [5:0] r;
        r = w;
        if (hiEn) {r[3], r[1]} = {w[1], w[3]};
        if (loEn) {r[2], r[0]} = {w[0], w[2]};
        return r;
    endfunction

    function automatic logic [5:0] swap12(input logic [5:0] w, input logic hiEn, input logic loEn);
        logic [5:0] r;
        r = w;
        if (hiEn) {r[5], r[3]} = {w[3], w[5]};
        if (loEn) {r[4], r[2]} = {w[2], w[4]};
        return r;
    endfunction

    // The key may only change while the pipe is empty, so every stage can read key_q directly.
    always_comb begin
        isIdle   = !v1_q && !v2_q && !v3_q;
        keyReady = isIdle && !bus.in_valid;
        keyFire  = bus.key_valid && keyReady;
        en3      = !v3_q || bus.out_ready;
        en2      = !v2_q || en3;
        en1      = !v1_q || en2;
        inReady  = en1 && !keyFire;
        inFire   = bus.in_valid && inReady;

        v1_d  = v1_q;
        v2_d  = v2_q;
        v3_d  = v3_q;
        w1_d  = w1_q;
        w2_d  = w2_q;
        w3_d  = w3_q;
        key_d = key_q;

        if (en1) begin
            v1_d = inFire;
            if (inFire)
                w1_d = swap01(pairSwap(bus.in_word, {key_q[11], key_q[9], key_q[7]}),
                              key_q[5], key_q[2]);
        end
        if (en2) begin
            v2_d = v1_q;
            if (v1_q)
                w2_d = swap01(swap12(w1_q, key_q[4], key_q[1]), key_q[3], key_q[0]);
        end
        if (en3) begin
            v3_d = v2_q;
            if (v2_q)
                w3_d = pairSwap(w2_q, {key_q[10], key_q[8], key_q[6]});
        end
        if (keyFire)
            key_d = bus.key_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            w1_q  <= '0;
            w2_q  <= '0;
            w3_q  <= '0;
            key_q <= '0;
        end else begin
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            v3_q  <= v3_d;
            w1_q  <= w1_d;
            w2_q  <= w2_d;
            w3_q  <= w3_d;
            key_q <= key_d;
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.key_ready = keyReady;
    assign bus.idle      = isIdle;
    assign bus.out_valid = v3_q;
    assign bus.out_word  = w3_q;
endmodule

// File: tb/tb_benes_unpermute_6.sv
// Directed bench for benes_unpermute_6: an independent forward-network model produces the
// permuted stimulus, and a scoreboard queue holds the original words expected at the output.
module tb_benes_unpermute_6;
    logic clk = 1'b0;
    logic reset;

    benes_unpermute_6_if bus();

    benes_unpermute_6 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          testCount  = 0;
    int          errorCount = 0;
    int          stallCount = 0;
    logic [5:0]  expQ[$];
    logic [63:0] seenMask;
    logic [11:0] currentKey;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [2:0] subnet(input logic [2:0] x, input logic [2:0] c);
        logic [2:0] y;
        y = x;
        if (c[0]) y = {y[2], y[0], y[1]};
        if (c[1]) y = {y[1], y[2], y[0]};
        if (c[2]) y = {y[2], y[0], y[1]};
        return y;
    endfunction

    // Forward Benes network: entry swaps, split odd/even into subnets, re-merge, exit swaps.
    function automatic logic [5:0] fwd(input logic [5:0] w, input logic [11:0] k);
        logic [5:0] o, a, b, r;
        logic [2:0] hi, lo;
        o = k[11:6];
        a = w;
        for (int j = 0; j < 3; j++)
            if (o[2*j]) begin a[2*j] = w[2*j+1]; a[2*j+1] = w[2*j]; end
        for (int j = 0; j < 3; j++) begin hi[j] = a[2*j+1]; lo[j] = a[2*j]; end
        hi = subnet(hi, k[5:3]);
        lo = subnet(lo, k[2:0]);
        for (int j = 0; j < 3; j++) begin b[2*j+1] = hi[j]; b[2*j] = lo[j]; end
        r = b;
        for (int j = 0; j < 3; j++)
            if (o[2*j+1]) begin r[2*j] = b[2*j+1]; r[2*j+1] = b[2*j]; end
        return r;
    endfunction

    always @(negedge clk) begin
        #2;
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (expQ.size() == 0)
                checkOutput("unexpected_out", 64'(bus.out_valid), 64'd0);
            else
                checkOutput("stream_word", 64'(bus.out_word), 64'(expQ.pop_front()));
            seenMask[bus.out_word] = 1'b1;
        end
    end

    task automatic applyStimulus(input logic [5:0] w, input logic [5:0] e);
        bit done = 0;
        int c = 0;
        while (!done) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_word  = w;
            #1;
            if (bus.in_ready) begin
                expQ.push_back(e);
                done = 1;
            end else begin
                stallCount++;
                c++;
                if (c > 60) begin
                    checkOutput("send_timeout", 64'(bus.in_ready), 64'd1);
                    done = 1;
                end
            end
        end
        @(posedge clk);
    endtask

    task automatic stopInput();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic loadKey(input logic [11:0] k, output int waited);
        bit done = 0;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.key_valid = 1'b1;
        bus.key_i     = k;
        waited = 0;
        while (!done) begin
            #1;
            if (bus.key_ready) begin
                done = 1;
            end else if (waited >= 60) begin
                checkOutput("key_accept_timeout", 64'(bus.key_ready), 64'd1);
                done = 1;
            end else begin
                waited++;
                @(negedge clk);
            end
        end
        @(posedge clk);
        currentKey = k;
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int c = 0;
        while ((!bus.idle || expQ.size() != 0) && c < 80) begin
            @(negedge clk);
            #3;
            c++;
        end
        checkOutput("drain_queue", 64'(expQ.size()), 64'd0);
        checkOutput("drain_idle", 64'(bus.idle), 64'd1);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [11:0] rtKeys [8];
        logic [5:0]  bpWords [4];
        logic [11:0] k;
        int          waited;

        rtKeys  = '{12'hFFF, 12'hA5C, 12'h3C3, 12'h7E1, 12'h040, 12'h001, 12'h555, 12'h8B6};
        bpWords = '{6'h05, 6'h1A, 6'h33, 6'h3E};

        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_word   = '0;
        bus.out_ready = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_i     = '0;
        currentKey    = '0;
        seenMask      = '0;

        #12;
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_out_word", 64'(bus.out_word), 64'd0);
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("rst_key_ready", 64'(bus.key_ready), 64'd1);
        checkOutput("rst_idle", 64'(bus.idle), 64'd1);
        @(negedge clk);
        reset = 1'b0;

        // Identity key: three-cycle latency.
        applyStimulus(6'h2D, 6'h2D);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1 checkOutput("lat_t1_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        #1 checkOutput("lat_t2_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        #1 checkOutput("lat_t3_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("lat_t3_word", 64'(bus.out_word), 64'h2D);
        waitDrain();

        stallCount = 0;
        for (int i = 0; i < 8; i++)
            applyStimulus(6'(i * 7 + 3), 6'(i * 7 + 3));
        stopInput();
        waitDrain();
        checkOutput("stream_stalls", 64'(stallCount), 64'd0);

        // Single-switch keys with hand-derived results.
        loadKey(12'h040, waited);
        applyStimulus(6'b000010, 6'b000001);
        loadKey(12'h001, waited);
        applyStimulus(6'b000100, 6'b000001);
        stopInput();
        waitDrain();

        for (int i = 0; i < 12; i++) begin
            k = (i < 8) ? rtKeys[i] : 12'($urandom_range(0, 4095));
            loadKey(k, waited);
            seenMask = '0;
            for (int w = 0; w < 64; w++)
                applyStimulus(fwd(6'(w), k), 6'(w));
            stopInput();
            waitDrain();
            checkOutput("bijection", seenMask, {64{1'b1}});
        end

        // Backpressure: three words fill the pipe, the fourth is refused.
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            applyStimulus(fwd(bpWords[i], currentKey), bpWords[i]);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_word  = fwd(bpWords[3], currentKey);
            #1;
            checkOutput("bp_in_ready", 64'(bus.in_ready), 64'd0);
            checkOutput("bp_out_valid", 64'(bus.out_valid), 64'd1);
            checkOutput("bp_hold_word", 64'(bus.out_word), 64'(bpWords[0]));
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        applyStimulus(fwd(bpWords[3], currentKey), bpWords[3]);
        stopInput();
        waitDrain();

        // Data and key offered together while idle: data wins.
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_word   = fwd(6'h27, currentKey);
        bus.key_valid = 1'b1;
        bus.key_i     = 12'hB39;
        #1;
        checkOutput("simul_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("simul_key_ready", 64'(bus.key_ready), 64'd0);
        expQ.push_back(6'h27);
        @(posedge clk);
        loadKey(12'hB39, waited);
        checkOutput("simul_key_wait", 64'(waited), 64'd3);
        applyStimulus(fwd(6'h0E, 12'hB39), 6'h0E);
        stopInput();
        waitDrain();

        // Key hazard: two words in flight keep the old key.
        applyStimulus(fwd(6'h11, currentKey), 6'h11);
        applyStimulus(fwd(6'h2A, currentKey), 6'h2A);
        loadKey(12'h6D2, waited);
        checkOutput("hazard_key_wait", 64'(waited), 64'd3);
        applyStimulus(fwd(6'h38, 12'h6D2), 6'h38);
        stopInput();
        waitDrain();

        // Reset with all three stages occupied.
        loadKey(12'h9A7, waited);
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            applyStimulus(fwd(bpWords[i], currentKey), bpWords[i]);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checkOutput("pre_rst_out_valid", 64'(bus.out_valid), 64'd1);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("mid_rst_idle", 64'(bus.idle), 64'd1);
        checkOutput("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("mid_rst_key_ready", 64'(bus.key_ready), 64'd1);
        checkOutput("mid_rst_out_word", 64'(bus.out_word), 64'd0);
        expQ.delete();
        currentKey = '0;
        @(negedge clk);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        applyStimulus(6'h15, 6'h15);
        applyStimulus(6'h2B, 6'h2B);
        stopInput();
        waitDrain();

        $display("[TB] %0d tests run, %0d failed", testCount, errorCount);
        $finish;
    end
endmodule
